// File: rtl/adder_pkg.sv
// Shared types and width helpers for the serial multi-byte adder arbiter.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned calc_w(input int unsigned nbytes);
    return 8 * nbytes;
  endfunction

  function automatic int unsigned calc_id_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Single-byte adder with carry; the one datapath shared by all requesters.
module adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin scheduler feeding one shared 8-bit adder, LSB byte first, with a
// registered carry between bytes and a valid/ready response port.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NBYTES = 4,
  localparam int unsigned W     = calc_w(NBYTES),
  localparam int unsigned ID_W  = calc_id_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_cout
);

  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0]   LastByte = KW'(NBYTES - 1);
  localparam logic [ID_W-1:0] LastId   = ID_W'(NREQ - 1);

  // MSB flags a hit; low bits are the first valid index at or after ptr.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!res[ID_W] && valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            cin_q, cin_d, carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;

  logic [ID_W:0]   pick;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  assign pick      = rr_pick(req_valid, rr_ptr_q);
  assign grant_vld = pick[ID_W];
  assign grant_idx = pick[ID_W-1:0];

  assign add_a   = a_q[{k_q, 3'b000} +: 8];
  assign add_b   = b_q[{k_q, 3'b000} +: 8];
  assign add_cin = (k_q == '0) ? cin_q : carry_q;

  adder_8bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StBusy;
      StBusy:  if (k_q == LastByte) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant is only visible while reset is released so nothing is accepted in reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle:  if (grant_vld && rst_n) req_ready[grant_idx] = 1'b1;
      StDone:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    id_d     = id_q;
    k_d      = k_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          a_d   = req_a[32'(grant_idx) * W +: W];
          b_d   = req_b[32'(grant_idx) * W +: W];
          cin_d = req_cin[grant_idx];
          id_d  = grant_idx;
          k_d   = '0;
        end
      end
      StBusy: begin
        sum_d[{k_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        k_d     = k_q + 1'b1;
      end
      StDone: begin
        if (rsp_ready) rr_ptr_d = (id_q == LastId) ? '0 : id_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= '0;
      k_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      k_q      <= k_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
